alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Two-requester arbiter and sequencer for the shared 8-bit ALU.
- Accepts opcode/operand requests from requester A (execute unit) and requester B (address/auxiliary unit) with valid/ready handshakes.
- Grants one request at a time using round-robin, drives the ALU inputs from registers, and waits a fixed latency.
- Captures operation_result/Flags/eq/gt/lt and returns them to the granted requester on a valid/ready response channel.

Parameters:
- ALU_LAT, 2, rising edges from the accept edge to the result-capture edge; legal range 1..15.
- OPW, 8, operand/result/opcode width; must be 8 to match the ALU.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- a_req_valid  in  1  requester A request valid
- a_req_ready  out  1  requester A request accepted (1-cycle pulse)
- a_op1  in  8  requester A operand1
- a_op2  in  8  requester A operand2
- a_sel  in  8  requester A ALU opcode
- b_req_valid  in  1  requester B request valid
- b_req_ready  out  1  requester B request accepted (1-cycle pulse)
- b_op1  in  8  requester B operand1
- b_op2  in  8  requester B operand2
- b_sel  in  8  requester B ALU opcode
- alu_operand1  out  8  to ALU operand1
- alu_operand2  out  8  to ALU operand2
- alu_sel  out  8  to ALU_sel
- alu_result  in  8  from ALU operation_result
- alu_flags  in  7  from ALU Flags
- alu_eq, alu_gt, alu_lt  in  1 each  from ALU compare outputs
- a_rsp_valid  out  1  response valid for A
- a_rsp_ready  in  1  A consumes response
- b_rsp_valid  out  1  response valid for B
- b_rsp_ready  in  1  B consumes response
- rsp_result  out  8  captured result (shared by both responses)
- rsp_flags  out  7  captured flags
- rsp_cmp  out  3  captured {eq,gt,lt}
- rsp_err  out  1  1 = opcode unsupported, no ALU operation performed
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst_n low at a rising edge): state=IDLE; last_grant=B, so A has priority first; counter=0.
  - All outputs reset to 0: ready pulses, rsp_valid, rsp_result, rsp_flags, rsp_cmp, rsp_err, alu_operand1/2, alu_sel, busy.
  - Reset overrides any state, including mid-WAIT and mid-RESP. The in-flight request is dropped with no response.
- Supported opcodes: 0x03-0x0A, 0x0D-0x11, 0x12, 0x14-0x18. Any other value is unsupported.
- State machine: IDLE -> WAIT -> RESP -> IDLE. IDLE can also go directly to RESP for an unsupported opcode.
- IDLE, no valid request: stay in IDLE; alu_sel=0x00.
- IDLE, one valid request: grant it.
- IDLE, both valid: grant the requester not equal to last_grant.
- On grant at edge T:
  - Pulse the granted xx_req_ready high for the cycle preceding edge T, so the handshake completes at T. The ready signals are combinational from state and valids, at most one high.
  - Register op1/op2/sel into alu_operand1/alu_operand2/alu_sel at T.
  - Record the grant id.
  - Supported opcode: load counter=ALU_LAT and go to WAIT.
  - Unsupported opcode: leave alu_sel=0x00 and go to RESP at T with rsp_err=1, rsp_result=0, rsp_flags=0, rsp_cmp=0.
- WAIT:
  - ALU inputs are held stable; the counter decrements each edge.
  - At the edge where the counter reaches 0 (the ALU_LAT-th edge after T), capture alu_result, alu_flags and {alu_eq,alu_gt,alu_lt} with rsp_err=0, then go to RESP.
  - Latency from accept to rsp_valid is exactly ALU_LAT cycles.
- RESP:
  - The granted xx_rsp_valid is high; the other stays 0.
  - rsp_* is held stable until xx_rsp_ready is high at an edge. That edge returns to IDLE, sets last_grant=grant id, and drops rsp_valid.
  - A new request can be accepted no earlier than the edge after the response handshake; back-to-back throughput is ALU_LAT+2 cycles.
- req_ready is never asserted outside IDLE. Requests arriving during WAIT/RESP wait with valid held; requesters must keep operands stable while valid.
- A requester deasserting valid before ready is legal; nothing is granted.
- rsp_ready high with rsp_valid low is ignored.
- busy = (state != IDLE).

Test Plan:
- Reset, ALU_LAT=2, A: ADD(0x03) op1=5 op2=3 -> a_req_ready at edge T; alu_sel=0x03 from T; a_rsp_valid at T+2; rsp_result=0x08, rsp_err=0; b_rsp_valid stays 0.
- A and B valid together after reset (A SUB 9-4, B AND 0xF0&0x3C) -> A served first (result 0x05), then B (result 0x30). Repeat both simultaneously -> A first again (last_grant=B). Then with only B pending after an A grant -> B granted.
- A opcode 0x02 -> a_rsp_valid at T+1, rsp_err=1, rsp_result=0x00, alu_sel stays 0x00, no WAIT state.
- A CMP(0x18) 7 vs 7, a_rsp_ready held low 5 cycles -> rsp_result, rsp_flags and rsp_cmp stable and a_rsp_valid high all 5 cycles; one cycle after ready, busy=0.
- rst_n low for one edge during WAIT -> next cycle busy=0, all outputs 0, no rsp_valid ever for the dropped request; a following A request is served normally.
- B request arriving during A's WAIT -> b_req_ready stays 0 until A's response handshake; B granted on the following edge.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter and sequencer for the shared 8-bit ALU.
// Two requesters take turns. Each one gets a registered operand set, a fixed-latency wait, and a held response.
module alu_arbiter #(
  parameter int ALU_LAT = 2,
  parameter int OPW     = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           a_req_valid,
  output logic           a_req_ready,
  input  logic [OPW-1:0] a_op1,
  input  logic [OPW-1:0] a_op2,
  input  logic [OPW-1:0] a_sel,
  input  logic           b_req_valid,
  output logic           b_req_ready,
  input  logic [OPW-1:0] b_op1,
  input  logic [OPW-1:0] b_op2,
  input  logic [OPW-1:0] b_sel,
  output logic [OPW-1:0] alu_operand1,
  output logic [OPW-1:0] alu_operand2,
  output logic [OPW-1:0] alu_sel,
  input  logic [OPW-1:0] alu_result,
  input  logic [6:0]     alu_flags,
  input  logic           alu_eq,
  input  logic           alu_gt,
  input  logic           alu_lt,
  output logic           a_rsp_valid,
  input  logic           a_rsp_ready,
  output logic           b_rsp_valid,
  input  logic           b_rsp_ready,
  output logic [OPW-1:0] rsp_result,
  output logic [6:0]     rsp_flags,
  output logic [2:0]     rsp_cmp,
  output logic           rsp_err,
  output logic           busy
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t         state, state_nxt;
  logic           last_grant;   // 0 = A, 1 = B
  logic           grant_id;
  logic [3:0]     cnt;
  logic           grant;
  logic           g_supported;
  logic           rsp_hs;
  logic [OPW-1:0] g_op1, g_op2, g_sel;

  function automatic logic op_supported(input logic [OPW-1:0] sel);
    return (sel >= OPW'(8'h03) && sel <= OPW'(8'h0A)) ||
           (sel >= OPW'(8'h0D) && sel <= OPW'(8'h12)) ||
           (sel >= OPW'(8'h14) && sel <= OPW'(8'h18));
  endfunction

  // Grant selection and next-state logic
  always_comb begin
    state_nxt   = state;
    a_req_ready = 1'b0;
    b_req_ready = 1'b0;
    g_op1       = a_op1;
    g_op2       = a_op2;
    g_sel       = a_sel;
    rsp_hs      = grant_id ? b_rsp_ready : a_rsp_ready;
    case (state)
      IDLE: begin
        // A wins unless B is also waiting and A was served last
        if (a_req_valid && (!b_req_valid || last_grant))
          a_req_ready = 1'b1;
        else if (b_req_valid)
          b_req_ready = 1'b1;
        if (b_req_ready) begin
          g_op1 = b_op1;
          g_op2 = b_op2;
          g_sel = b_sel;
        end
        if (a_req_ready || b_req_ready)
          state_nxt = op_supported(g_sel) ? WAIT : RESP;
      end
      WAIT: if (cnt == 4'd1) state_nxt = RESP;
      RESP: if (rsp_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    grant       = a_req_ready || b_req_ready;
    g_supported = op_supported(g_sel);
    a_rsp_valid = (state == RESP) && !grant_id;
    b_rsp_valid = (state == RESP) && grant_id;
    busy        = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      grant_id     <= 1'b0;
      cnt          <= 4'd0;
      alu_operand1 <= '0;
      alu_operand2 <= '0;
      alu_sel      <= '0;
      rsp_result   <= '0;
      rsp_flags    <= '0;
      rsp_cmp      <= '0;
      rsp_err      <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (grant) begin
            grant_id     <= b_req_ready;
            alu_operand1 <= g_op1;
            alu_operand2 <= g_op2;
            if (g_supported) begin
              alu_sel <= g_sel;
              cnt     <= 4'(ALU_LAT);
            end else begin
              // Unsupported opcode: answer immediately, ALU stays idle
              alu_sel    <= '0;
              rsp_err    <= 1'b1;
              rsp_result <= '0;
              rsp_flags  <= '0;
              rsp_cmp    <= '0;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            rsp_result <= alu_result;
            rsp_flags  <= alu_flags;
            rsp_cmp    <= {alu_eq, alu_gt, alu_lt};
            rsp_err    <= 1'b0;
          end
        end
        RESP: begin
          if (rsp_hs) begin
            last_grant <= grant_id;
            alu_sel    <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU stub.
module tb_alu_arbiter;
  localparam int ALU_LAT = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_req_valid, a_req_ready, b_req_valid, b_req_ready;
  logic [7:0] a_op1, a_op2, a_sel, b_op1, b_op2, b_sel;
  logic [7:0] alu_operand1, alu_operand2, alu_sel, alu_result;
  logic [6:0] alu_flags;
  logic       alu_eq, alu_gt, alu_lt;
  logic       a_rsp_valid, a_rsp_ready, b_rsp_valid, b_rsp_ready;
  logic [7:0] rsp_result;
  logic [6:0] rsp_flags;
  logic [2:0] rsp_cmp;
  logic       rsp_err, busy;

  int checks = 0;
  int failures = 0;

  alu_arbiter #(.ALU_LAT(ALU_LAT), .OPW(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready),
    .a_op1(a_op1), .a_op2(a_op2), .a_sel(a_sel),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready),
    .b_op1(b_op1), .b_op2(b_op2), .b_sel(b_sel),
    .alu_operand1(alu_operand1), .alu_operand2(alu_operand2), .alu_sel(alu_sel),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .alu_eq(alu_eq), .alu_gt(alu_gt), .alu_lt(alu_lt),
    .a_rsp_valid(a_rsp_valid), .a_rsp_ready(a_rsp_ready),
    .b_rsp_valid(b_rsp_valid), .b_rsp_ready(b_rsp_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_cmp(rsp_cmp),
    .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // ALU stub: 03 add, 04 sub, 05 and, otherwise xor; flags = {sel[2:0], op1[3:0]}
  always_comb begin
    case (alu_sel)
      8'h03:   alu_result = alu_operand1 + alu_operand2;
      8'h04:   alu_result = alu_operand1 - alu_operand2;
      8'h05:   alu_result = alu_operand1 & alu_operand2;
      default: alu_result = alu_operand1 ^ alu_operand2;
    endcase
    alu_flags = {alu_sel[2:0], alu_operand1[3:0]};
    alu_eq    = (alu_operand1 == alu_operand2);
    alu_gt    = (alu_operand1 > alu_operand2);
    alu_lt    = (alu_operand1 < alu_operand2);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    a_req_valid = 0; b_req_valid = 0; a_rsp_ready = 0; b_rsp_ready = 0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // The requester's valid must already be driven and be the one granted this cycle.
  task automatic run_txn(input string tag, input logic is_a, input logic [7:0] exp_res,
                         input logic [6:0] exp_flags, input logic [2:0] exp_cmp);
    #1;
    check({tag, "_req_ready"}, is_a ? a_req_ready : b_req_ready, 1);
    check({tag, "_other_ready"}, is_a ? b_req_ready : a_req_ready, 0);
    tick();
    if (is_a) a_req_valid = 0; else b_req_valid = 0;
    check({tag, "_busy"}, busy, 1);
    repeat (ALU_LAT - 1) tick();
    check({tag, "_early_rsp"}, is_a ? a_rsp_valid : b_rsp_valid, 0);
    tick();
    check({tag, "_rsp_valid"}, is_a ? a_rsp_valid : b_rsp_valid, 1);
    check({tag, "_other_rsp"}, is_a ? b_rsp_valid : a_rsp_valid, 0);
    check({tag, "_result"}, rsp_result, exp_res);
    check({tag, "_flags"}, rsp_flags, exp_flags);
    check({tag, "_cmp"}, rsp_cmp, exp_cmp);
    check({tag, "_err"}, rsp_err, 0);
    if (is_a) a_rsp_ready = 1; else b_rsp_ready = 1;
    tick();
    a_rsp_ready = 0; b_rsp_ready = 0;
    check({tag, "_idle"}, busy, 0);
    check({tag, "_sel_clr"}, alu_sel, 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    a_op1 = 0; a_op2 = 0; a_sel = 0; b_op1 = 0; b_op2 = 0; b_sel = 0;
    rst_n = 1'b0;
    a_req_valid = 0; b_req_valid = 0; a_rsp_ready = 0; b_rsp_ready = 0;
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_alu_sel", alu_sel, 0);
    check("rst_result", rsp_result, 0);
    check("rst_rsp_valid", {a_rsp_valid, b_rsp_valid}, 0);
    rst_n = 1'b1;
    tick();

    // Single A ADD 5+3
    a_op1 = 8'd5; a_op2 = 8'd3; a_sel = 8'h03; a_req_valid = 1;
    #1;
    check("add_ready", a_req_ready, 1);
    tick();
    a_req_valid = 0;
    check("add_alu_sel", alu_sel, 8'h03);
    check("add_alu_op1", alu_operand1, 8'd5);
    tick();
    check("add_early", a_rsp_valid, 0);
    tick();
    check("add_rsp_valid", a_rsp_valid, 1);
    check("add_b_rsp", b_rsp_valid, 0);
    check("add_result", rsp_result, 8'h08);
    check("add_flags", rsp_flags, 7'h35);
    check("add_cmp", rsp_cmp, 3'b010);
    check("add_err", rsp_err, 0);
    a_rsp_ready = 1;
    tick();
    a_rsp_ready = 0;
    check("add_idle", busy, 0);

    // Simultaneous A and B after reset: A first, then B
    do_reset();
    a_op1 = 8'd9; a_op2 = 8'd4; a_sel = 8'h04; a_req_valid = 1;
    b_op1 = 8'hF0; b_op2 = 8'h3C; b_sel = 8'h05; b_req_valid = 1;
    run_txn("rr1_a", 1'b1, 8'h05, 7'h49, 3'b010);
    run_txn("rr1_b", 1'b0, 8'h30, 7'h50, 3'b010);
    a_req_valid = 1; b_req_valid = 1;
    run_txn("rr2_a", 1'b1, 8'h05, 7'h49, 3'b010);
    run_txn("rr2_b", 1'b0, 8'h30, 7'h50, 3'b010);

    // Unsupported opcode 0x02
    a_op1 = 8'd1; a_op2 = 8'd1; a_sel = 8'h02; a_req_valid = 1;
    #1;
    check("bad_ready", a_req_ready, 1);
    tick();
    a_req_valid = 0;
    check("bad_rsp_valid", a_rsp_valid, 1);
    check("bad_err", rsp_err, 1);
    check("bad_result", rsp_result, 8'h00);
    check("bad_flags", rsp_flags, 7'h00);
    check("bad_cmp", rsp_cmp, 3'b000);
    check("bad_alu_sel", alu_sel, 8'h00);
    a_rsp_ready = 1;
    tick();
    a_rsp_ready = 0;
    check("bad_idle", busy, 0);

    // CMP 7 vs 7 with response backpressure; stray b_rsp_ready must be ignored
    a_op1 = 8'd7; a_op2 = 8'd7; a_sel = 8'h18; a_req_valid = 1;
    #1;
    check("cmp_ready", a_req_ready, 1);
    tick();
    a_req_valid = 0;
    tick();
    tick();
    b_rsp_ready = 1;
    for (int i = 0; i < 5; i++) begin
      check("cmp_hold_valid", a_rsp_valid, 1);
      check("cmp_hold_result", rsp_result, 8'h00);
      check("cmp_hold_flags", rsp_flags, 7'h07);
      check("cmp_hold_cmp", rsp_cmp, 3'b100);
      tick();
    end
    b_rsp_ready = 0;
    a_rsp_ready = 1;
    tick();
    a_rsp_ready = 0;
    check("cmp_idle", busy, 0);

    // Reset during WAIT drops the request
    a_op1 = 8'd5; a_op2 = 8'd3; a_sel = 8'h03; a_req_valid = 1;
    tick();
    a_req_valid = 0;
    check("rw_busy_wait", busy, 1);
    rst_n = 0;
    tick();
    rst_n = 1;
    check("rw_busy", busy, 0);
    check("rw_alu_sel", alu_sel, 0);
    check("rw_alu_op1", alu_operand1, 0);
    check("rw_result", rsp_result, 0);
    check("rw_flags", rsp_flags, 0);
    for (int i = 0; i < 4; i++) begin
      check("rw_no_rsp", {a_rsp_valid, b_rsp_valid}, 0);
      tick();
    end
    a_op1 = 8'd5; a_op2 = 8'd3; a_sel = 8'h03; a_req_valid = 1;
    run_txn("rw_after", 1'b1, 8'h08, 7'h35, 3'b010);

    // B arrives during A's WAIT and is held off until A's response handshake
    a_op1 = 8'd5; a_op2 = 8'd3; a_sel = 8'h03; a_req_valid = 1;
    #1;
    check("late_a_ready", a_req_ready, 1);
    tick();
    a_req_valid = 0;
    b_op1 = 8'd2; b_op2 = 8'd2; b_sel = 8'h03; b_req_valid = 1;
    #1;
    check("late_b_wait1", b_req_ready, 0);
    tick();
    check("late_b_wait2", b_req_ready, 0);
    tick();
    check("late_a_rsp", a_rsp_valid, 1);
    check("late_b_resp", b_req_ready, 0);
    a_rsp_ready = 1;
    tick();
    a_rsp_ready = 0;
    run_txn("late_b", 1'b0, 8'h04, 7'h32, 3'b100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
